// File: rtl/bin2oht_pipe_if.sv
// Stream bundle for bin2oht_pipe: binary index in, one-hot vector out.
// The slave modport is the decoder's view; master is the producer/consumer side.
interface bin2oht_pipe_if #(
  parameter int WIDTH = 16
);
  localparam int WIDTH_LOG = $clog2(WIDTH);

  logic                 i_vld;
  logic                 i_rdy;
  logic [WIDTH_LOG-1:0] i_bin;
  logic                 o_vld;
  logic                 o_rdy;
  logic [WIDTH-1:0]     o_oht;
  logic                 o_err;

  modport slave (
    input  i_vld, i_bin, o_rdy,
    output i_rdy, o_vld, o_oht, o_err
  );

  modport master (
    output i_vld, i_bin, o_rdy,
    input  i_rdy, o_vld, o_oht, o_err
  );
endinterface

// File: rtl/bin2oht_pipe.sv
// Two-stage pipelined binary-to-one-hot decoder: group select, then in-group select.
// Define BIN2OHT_PIPE_SKID_EN for a 1-entry input skid buffer that registers i_rdy.
module bin2oht_pipe #(
  parameter int WIDTH = 16,
  parameter int SPLIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2oht_pipe_if.slave bus
);
  localparam int WIDTH_LOG = $clog2(WIDTH);
  localparam int SPLIT_LOG = $clog2(SPLIT);
  localparam int GROUPS    = (WIDTH + SPLIT - 1) / SPLIT;
  localparam bit POW2      = (WIDTH == (1 << WIDTH_LOG));

  logic                 s1_vld_q, s1_vld_d;
  logic [SPLIT_LOG-1:0] s1_lo_q, s1_lo_d;
  logic [GROUPS-1:0]    s1_grp_q, s1_grp_d;
  logic                 s1_err_q, s1_err_d;

  logic                 o_vld_q, o_vld_d;
  logic [WIDTH-1:0]     o_oht_q, o_oht_d;
  logic                 o_err_q, o_err_d;

  logic                 s1_rdy;
  logic                 s2_rdy;
  logic                 src_vld;
  logic [WIDTH_LOG-1:0] src_bin;
  logic [GROUPS-1:0]    grp_dec;
  logic                 err_dec;
  logic [WIDTH-1:0]     oht_dec;

  assign s2_rdy = !o_vld_q || bus.o_rdy;
  assign s1_rdy = !s1_vld_q || s2_rdy;

`ifdef BIN2OHT_PIPE_SKID_EN
  logic                 skid_full_q, skid_full_d;
  logic [WIDTH_LOG-1:0] skid_bin_q, skid_bin_d;

  // i_rdy comes only from the skid flag, so o_rdy has no combinational path to it
  assign bus.i_rdy = rst_n && !skid_full_q;

  always_comb begin
    skid_full_d = skid_full_q;
    skid_bin_d  = skid_bin_q;
    src_vld     = skid_full_q || (bus.i_vld && bus.i_rdy);
    src_bin     = skid_full_q ? skid_bin_q : bus.i_bin;
    if (skid_full_q) begin
      if (s1_rdy) skid_full_d = 1'b0;
    end else if (bus.i_vld && bus.i_rdy && !s1_rdy) begin
      skid_full_d = 1'b1;
      skid_bin_d  = bus.i_bin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full_q <= 1'b0;
      skid_bin_q  <= '0;
    end else begin
      skid_full_q <= skid_full_d;
      skid_bin_q  <= skid_bin_d;
    end
  end
`else
  assign bus.i_rdy = rst_n && s1_rdy;

  always_comb begin
    src_vld = bus.i_vld && bus.i_rdy;
    src_bin = bus.i_bin;
  end
`endif

  always_comb begin
    grp_dec = '0;
    err_dec = POW2 ? 1'b0 : ({1'b0, src_bin} >= (WIDTH_LOG + 1)'(WIDTH));
    for (int k = 0; k < GROUPS; k++) begin
      if (int'(src_bin >> SPLIT_LOG) == k) grp_dec[k] = 1'b1;
    end
    if (err_dec) grp_dec = '0;
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_lo_d  = s1_lo_q;
    s1_grp_d = s1_grp_q;
    s1_err_d = s1_err_q;
    if (s1_rdy) begin
      s1_vld_d = src_vld;
      if (src_vld) begin
        s1_lo_d  = src_bin[SPLIT_LOG-1:0];
        s1_grp_d = grp_dec;
        s1_err_d = err_dec;
      end
    end
  end

  // Walking output bits keeps the padding of a partial last group out of range
  always_comb begin
    oht_dec = '0;
    for (int n = 0; n < WIDTH; n++) begin
      oht_dec[n] = s1_grp_q[n / SPLIT] && (s1_lo_q == SPLIT_LOG'(n % SPLIT));
    end
  end

  always_comb begin
    o_vld_d = o_vld_q;
    o_oht_d = o_oht_q;
    o_err_d = o_err_q;
    if (s2_rdy) begin
      o_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        o_oht_d = oht_dec;
        o_err_d = s1_err_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_lo_q  <= '0;
      s1_grp_q <= '0;
      s1_err_q <= 1'b0;
      o_vld_q  <= 1'b0;
      o_oht_q  <= '0;
      o_err_q  <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_lo_q  <= s1_lo_d;
      s1_grp_q <= s1_grp_d;
      s1_err_q <= s1_err_d;
      o_vld_q  <= o_vld_d;
      o_oht_q  <= o_oht_d;
      o_err_q  <= o_err_d;
    end
  end

  assign bus.o_vld = o_vld_q;
  assign bus.o_oht = o_oht_q;
  assign bus.o_err = o_err_q;
endmodule

// File: tb/tb_bin2oht_pipe.sv
// Bench for bin2oht_pipe: WIDTH=16/SPLIT=4 and WIDTH=10/SPLIT=4 instances,
// queue-based reference model plus literal expectations on directed vectors.
module tb_bin2oht_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bin2oht_pipe_if #(.WIDTH(16)) bus16 ();
  bin2oht_pipe_if #(.WIDTH(10)) bus10 ();

  bin2oht_pipe #(.WIDTH(16), .SPLIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  bin2oht_pipe #(.WIDTH(10), .SPLIT(4)) dut10 (.clk(clk), .rst_n(rst_n), .bus(bus10));

  int checks = 0;
  int errors = 0;

  logic [15:0] q16[$];
  logic [15:0] log16[$];
  logic [9:0]  q10_oht[$];
  logic        q10_err[$];
  logic [9:0]  log10_oht[$];
  logic        log10_err[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference: a legal index sets exactly bit b; anything past WIDTH decodes to zero
  function automatic logic [15:0] m16(input int b);
    return (b < 16) ? 16'(32'd1 << b) : 16'h0;
  endfunction

  function automatic logic [9:0] m10(input int b);
    return (b < 10) ? 10'(32'd1 << b) : 10'h0;
  endfunction

  logic [15:0] prev16;
  logic        hold16 = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      q16.delete();
      hold16 = 1'b0;
    end else begin
      if (bus16.o_vld) begin
        if (hold16) chk("hold16", bus16.o_oht, prev16);
        chk("err16", bus16.o_err, 1'b0);
        if (!bus16.o_err) chk("onehot16", $onehot(bus16.o_oht), 1);
        if (bus16.o_rdy) begin
          if (q16.size() == 0) fail_now("spurious16");
          else chk("oht16", bus16.o_oht, q16.pop_front());
          log16.push_back(bus16.o_oht);
        end
      end
      hold16 = bus16.o_vld && !bus16.o_rdy;
      prev16 = bus16.o_oht;
      if (bus16.i_vld && bus16.i_rdy) q16.push_back(m16(int'(bus16.i_bin)));
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q10_oht.delete();
      q10_err.delete();
    end else begin
      if (bus10.o_vld && bus10.o_rdy) begin
        if (q10_oht.size() == 0) fail_now("spurious10");
        else begin
          chk("oht10", bus10.o_oht, q10_oht.pop_front());
          chk("err10", bus10.o_err, q10_err.pop_front());
        end
        log10_oht.push_back(bus10.o_oht);
        log10_err.push_back(bus10.o_err);
      end
      if (bus10.i_vld && bus10.i_rdy) begin
        q10_oht.push_back(m10(int'(bus10.i_bin)));
        q10_err.push_back(int'(bus10.i_bin) >= 10);
      end
    end
  end

  task automatic send16(input logic [3:0] b);
    int n = 0;
    bit ok = 1'b0;
    bus16.i_vld = 1'b1;
    bus16.i_bin = b;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus16.i_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) fail_now("send16_timeout");
    bus16.i_vld = 1'b0;
    bus16.i_bin = 'x;
  endtask

  task automatic send10(input logic [3:0] b);
    int n = 0;
    bit ok = 1'b0;
    bus10.i_vld = 1'b1;
    bus10.i_bin = b;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = bus10.i_rdy;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) fail_now("send10_timeout");
    bus10.i_vld = 1'b0;
    bus10.i_bin = 'x;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q16.size() != 0 || q10_oht.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain16"}, q16.size(), 0);
    chk({name, "_drain10"}, q10_oht.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int v10[4] = '{9, 10, 15, 4};
    bit done;

    bus16.i_vld = 1'b0; bus16.i_bin = 'x; bus16.o_rdy = 1'b1;
    bus10.i_vld = 1'b0; bus10.i_bin = 'x; bus10.o_rdy = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_irdy16", bus16.i_rdy, 1'b1);
    chk("rst_ovld16", bus16.o_vld, 1'b0);
    chk("rst_oht16", bus16.o_oht, 16'h0000);
    chk("rst_err16", bus16.o_err, 1'b0);
    chk("rst_irdy10", bus10.i_rdy, 1'b1);
    repeat (10) begin
      @(negedge clk);
      chk("idle_ovld16", bus16.o_vld, 1'b0);
    end
    @(posedge clk);
    #1;

    // Back-to-back sweep 0..15
    log16.delete();
    fork
      for (int i = 0; i < 16; i++) send16(4'(i));
      begin
        int n = 0;
        int lat = 0;
        int run = 0;
        do begin @(negedge clk); n++; end while (!(bus16.i_vld && bus16.i_rdy) && n < 50);
        do begin @(negedge clk); lat++; end while (!bus16.o_vld && lat < 10);
        chk("latency", lat, 2);
        while (bus16.o_vld && run < 40) begin run++; @(negedge clk); end
        chk("sweep_run", run, 16);
      end
    join
    drain("sweep");
    chk("sweep_cnt", log16.size(), 16);
    chk("sweep_0", log16[0], 16'h0001);
    chk("sweep_7", log16[7], 16'h0080);
    chk("sweep_15", log16[15], 16'h8000);

    // Non-power-of-two width
    log10_oht.delete();
    log10_err.delete();
    for (int i = 0; i < 4; i++) send10(4'(v10[i]));
    drain("w10");
    chk("w10_cnt", log10_oht.size(), 4);
    chk("w10_9_oht", log10_oht[0], 10'h200);
    chk("w10_9_err", log10_err[0], 1'b0);
    chk("w10_10_oht", log10_oht[1], 10'h000);
    chk("w10_10_err", log10_err[1], 1'b1);
    chk("w10_15_oht", log10_oht[2], 10'h000);
    chk("w10_15_err", log10_err[2], 1'b1);
    chk("w10_4_oht", log10_oht[3], 10'h010);
    chk("w10_4_err", log10_err[3], 1'b0);

    // Backpressure
    log16.delete();
    bus16.o_rdy = 1'b0;
    fork
      begin send16(4'd3); send16(4'd7); send16(4'd12); end
      begin
        repeat (2) @(negedge clk);
        repeat (5) begin
          @(negedge clk);
          chk("bp_ovld", bus16.o_vld, 1'b1);
          chk("bp_oht", bus16.o_oht, 16'h0008);
        end
        chk("bp_irdy", bus16.i_rdy, 1'b0);
        @(posedge clk);
        #1;
        bus16.o_rdy = 1'b1;
      end
    join
    drain("bp");
    chk("bp_cnt", log16.size(), 3);
    chk("bp_0", log16[0], 16'h0008);
    chk("bp_1", log16[1], 16'h0080);
    chk("bp_2", log16[2], 16'h1000);

    // Random traffic against the reference queue
    log16.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
          send16(4'($urandom_range(0, 15)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          bus16.o_rdy = ($urandom_range(0, 3) != 0);
        end
        bus16.o_rdy = 1'b1;
      end
    join
    drain("rand");
    chk("rand_cnt", log16.size(), 1000);

    // Asynchronous reset with two beats in flight
    bus16.o_rdy = 1'b0;
    send16(4'd1);
    send16(4'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ovld16", bus16.o_vld, 1'b0);
    chk("arst_oht16", bus16.o_oht, 16'h0000);
    chk("arst_irdy16", bus16.i_rdy, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    log16.delete();
    bus16.o_rdy = 1'b1;
    send16(4'd5);
    drain("arst");
    chk("arst_cnt", log16.size(), 1);
    chk("arst_first", log16[0], 16'h0020);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bin2oht_pipe.md
Name: bin2oht_pipe

Overview:
- Pipelined binary-to-one-hot decoder; the inverse of the `oht2bin` encoder.
- Accepts a binary index through a valid/ready handshake and decodes it in two registered stages: group select, then in-group select. Emits a WIDTH-bit one-hot vector through a valid/ready handshake.
- Sits in front of arbiters and mux selects that need one-hot controls from a binary index stream. Supports full throughput and backpressure.

Parameters:
- WIDTH, 16, one-hot output width; any value >= 2, need not be a power of two.
- SPLIT, 4, in-group decode width; power of two, 2 <= SPLIT <= WIDTH.
- WIDTH_LOG, $clog2(WIDTH), localparam, binary width.
- SPLIT_LOG, $clog2(SPLIT), localparam, in-group index width.
- GROUPS, ceil(WIDTH/SPLIT), localparam, number of SPLIT-wide groups.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- i_vld  input  1  input index valid.
- i_rdy  output  1  input ready.
- i_bin  input  WIDTH_LOG  binary index.
- o_vld  output  1  output valid.
- o_rdy  input  1  output ready.
- o_oht  output  WIDTH  one-hot result.
- o_err  output  1  index out of range (i_bin >= WIDTH); qualified by o_vld.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous and active-low. On assertion, all state clears immediately, without waiting for a clock edge.
- Reset values: o_vld=0, o_oht=0, o_err=0, both stage valid flags=0, optional skid register empty. i_rdy=1 once reset is released (i_rdy=0 while rst_n=0).
- Handshake: a transfer happens on a rising edge where vld&&rdy.
  - Once o_vld is asserted, o_oht and o_err hold stable until o_rdy is seen.
  - i_rdy never depends on i_vld.
- Stage 1 (grp), registered:
  - Captures the in-group index lo = i_bin[SPLIT_LOG-1:0].
  - Captures the group one-hot g (GROUPS bits): g[i_bin>>SPLIT_LOG]=1.
  - Captures err1 = (i_bin >= WIDTH).
  - If err1, g = 0.
- Stage 2 (oht), registered:
  - o_oht[k*SPLIT+j] = g[k] & (lo==j), for all k*SPLIT+j < WIDTH.
  - Bits at positions >= WIDTH in the last group are discarded.
  - o_err = err1.
- Width rules:
  - In range: o_oht has exactly one bit set, and o_oht == 1<<i_bin.
  - Out of range: o_oht = 0 and o_err = 1.
  - For power-of-two WIDTH, o_err is constant 0.
- Latency: 2 cycles from input handshake to o_vld, with no stalls.
- Throughput: 1 transfer per cycle when o_rdy=1 continuously.
- Stage advance (per stage): stage_rdy = !stage_vld || next_rdy.
  - When the stage captures, stage_vld <= upstream valid; data is loaded only on capture.
  - A stalled stage holds its data.
- Simultaneous events:
  - Stage full, downstream accepts, and a new input presented in the same cycle: the stage reloads and stays valid, with no bubble.
  - Both stages full and o_rdy=0: i_rdy=0 (without skid).
- Reset mid-operation: in-flight items are dropped; no partial or duplicate output after release.
- X handling: i_bin is ignored unless i_vld=1. Stage registers load only on capture, so X on idle inputs must not propagate to o_oht.

Optional Feature:
- Macro: BIN2OHT_PIPE_SKID_EN.
- When defined:
  - A 1-entry skid buffer is added at the input, and i_rdy is driven directly from a flop (!skid_full).
  - The combinational path from o_rdy to i_rdy is removed.
  - When stage 1 cannot accept, a beat offered while i_rdy=1 is caught in skid and drains first on the next stage-1 capture.
  - Ordering is preserved and latency is unchanged when the skid is empty.
- When undefined: no skid; i_rdy = stage-1 ready, combinational from o_rdy.
- Functional output sequence is identical in both builds.

Test Plan:
- Reset/idle, WIDTH=16, SPLIT=4:
  - After reset, o_vld=0, o_oht=16'h0000 and i_rdy=1 observed with rst_n=1.
  - With i_vld=0 and i_bin=X for 10 cycles: o_vld stays 0.
- Sweep, WIDTH=16:
  - i_bin=0..15 back-to-back with o_rdy=1: o_oht = 16'h0001, 16'h0002, ..., 16'h8000, in order.
  - First o_vld appears 2 cycles after the first transfer; o_vld stays 1 for 16 consecutive cycles; o_err=0 throughout.
- Out of range, WIDTH=10, SPLIT=4:
  - i_bin=9 gives o_oht=10'h200, o_err=0.
  - i_bin=10 and i_bin=15 each give o_oht=0, o_err=1.
  - i_bin=4 gives o_oht=10'h010.
- Backpressure:
  - Issue 3,7,12 with o_rdy=0 for 5 cycles: o_oht=16'h0008 held stable; i_rdy drops to 0 once the pipeline is full.
  - Release o_rdy: 16'h0008, 16'h0080, 16'h1000 delivered with no loss or duplication.
- Random:
  - 1000 beats with random i_vld, o_rdy and i_bin, checked against a reference queue: o_oht == 1<<i_bin, and $onehot(o_oht) whenever o_vld && !o_err.
  - Run with and without BIN2OHT_PIPE_SKID_EN.
- Async reset mid-stream:
  - Drop rst_n between clock edges with 2 beats in flight: o_vld=0 immediately.
  - After release, the first output corresponds to the first post-reset input.
